// File: rtl/bp_be_late_wb_queue.sv
// Late-load writeback queue: a shared entry pool with an age matrix; each regfile class retires
// oldest-first on its own port. Optional same-cycle bypass is enabled by BP_BE_LATE_WB_BYPASS_EN.
module bp_be_late_wb_queue #(
  parameter int unsigned els_p            = 4,
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned reg_addr_width_p = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         enq_v_i,
  output logic                         enq_ready_o,
  input  logic                         enq_float_i,
  input  logic [reg_addr_width_p-1:0]  enq_rd_addr_i,
  input  logic [data_width_p-1:0]      enq_data_i,
  output logic                         iwb_v_o,
  output logic [reg_addr_width_p-1:0]  iwb_rd_addr_o,
  output logic [data_width_p-1:0]      iwb_data_o,
  input  logic                         iwb_yumi_i,
  output logic                         fwb_v_o,
  output logic [reg_addr_width_p-1:0]  fwb_rd_addr_o,
  output logic [data_width_p-1:0]      fwb_data_o,
  input  logic                         fwb_yumi_i,
  input  logic [reg_addr_width_p-1:0]  probe_rd_addr_i,
  input  logic                         probe_float_i,
  output logic                         probe_hit_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

  logic [els_p-1:0]            valid_q, valid_d;
  logic [els_p-1:0]            float_q, float_d;
  logic [els_p-1:0]            age_q   [els_p];
  logic [els_p-1:0]            age_d   [els_p];
  logic [reg_addr_width_p-1:0] addr_q  [els_p];
  logic [reg_addr_width_p-1:0] addr_d  [els_p];
  logic [data_width_p-1:0]     data_q  [els_p];
  logic [data_width_p-1:0]     data_d  [els_p];

  logic [els_p-1:0]            int_mask, fp_mask, int_old, fp_old;
  logic [idx_width_lp-1:0]     free_idx;
  logic                        enq_fire, enq_is_x0, enq_store, byp_int, byp_fp;
  logic [reg_addr_width_p-1:0] int_addr, fp_addr;
  logic [data_width_p-1:0]     int_data, fp_data;
  logic [cnt_width_lp-1:0]     count;

  assign int_mask    = valid_q & ~float_q;
  assign fp_mask     = valid_q & float_q;
  assign enq_ready_o = ~&valid_q;
  assign enq_fire    = enq_v_i & enq_ready_o;
  assign enq_is_x0   = ~enq_float_i & (enq_rd_addr_i == '0);

`ifdef BP_BE_LATE_WB_BYPASS_EN
  assign byp_int = reset_n_i & enq_fire & ~enq_float_i & ~enq_is_x0 & ~|int_mask;
  assign byp_fp  = reset_n_i & enq_fire & enq_float_i & ~|fp_mask;
`else
  assign byp_int = 1'b0;
  assign byp_fp  = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never occupies a slot.
  assign enq_store = enq_fire & ~enq_is_x0 & ~(byp_int & iwb_yumi_i) & ~(byp_fp & fwb_yumi_i);

  // age_q[j][i] set means entry j is older than entry i; the diagonal stays clear.
  always_comb begin
    int_old = '0;
    fp_old  = '0;
    for (int i = 0; i < int'(els_p); i++) begin
      int_old[i] = int_mask[i];
      fp_old[i]  = fp_mask[i];
      for (int j = 0; j < int'(els_p); j++) begin
        if (age_q[j][i] && int_mask[j]) int_old[i] = 1'b0;
        if (age_q[j][i] && fp_mask[j])  fp_old[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = int'(els_p) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = idx_width_lp'(i);
    end
  end

  always_comb begin
    int_addr = '0;
    int_data = '0;
    fp_addr  = '0;
    fp_data  = '0;
    for (int i = 0; i < int'(els_p); i++) begin
      if (int_old[i]) begin
        int_addr = addr_q[i];
        int_data = data_q[i];
      end
      if (fp_old[i]) begin
        fp_addr = addr_q[i];
        fp_data = data_q[i];
      end
    end
  end

  assign iwb_v_o       = |int_mask | byp_int;
  assign iwb_rd_addr_o = byp_int ? enq_rd_addr_i : int_addr;
  assign iwb_data_o    = byp_int ? enq_data_i : int_data;
  assign fwb_v_o       = |fp_mask | byp_fp;
  assign fwb_rd_addr_o = byp_fp ? enq_rd_addr_i : fp_addr;
  assign fwb_data_o    = byp_fp ? enq_data_i : fp_data;

  always_comb begin
    probe_hit_o = 1'b0;
    for (int i = 0; i < int'(els_p); i++) begin
      if (valid_q[i] && (float_q[i] == probe_float_i) && (addr_q[i] == probe_rd_addr_i)) begin
        probe_hit_o = 1'b1;
      end
    end
    if (!probe_float_i && (probe_rd_addr_i == '0)) probe_hit_o = 1'b0;
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(els_p); i++) begin
      count = count + cnt_width_lp'(valid_q[i]);
    end
  end
  assign count_o = count;

  always_comb begin
    valid_d = valid_q;
    float_d = float_q;
    age_d   = age_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (iwb_yumi_i) valid_d = valid_d & ~int_old;
    if (fwb_yumi_i) valid_d = valid_d & ~fp_old;
    if (enq_store) begin
      valid_d[free_idx] = 1'b1;
      float_d[free_idx] = enq_float_i;
      addr_d[free_idx]  = enq_rd_addr_i;
      data_d[free_idx]  = enq_data_i;
      for (int j = 0; j < int'(els_p); j++) begin
        age_d[free_idx][j] = 1'b0;
        if (idx_width_lp'(j) != free_idx) age_d[j][free_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(els_p); i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    float_q <= float_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
  end

  iwb_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    iwb_yumi_i |-> iwb_v_o);
  fwb_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fwb_yumi_i |-> fwb_v_o);

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Bench for bp_be_late_wb_queue: per-class FIFO reference model, directed scenarios, random traffic.
module tb_bp_be_late_wb_queue;
  localparam int unsigned Els = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enq_v, enq_ready, enq_float;
  logic [AW-1:0] enq_rd_addr;
  logic [DW-1:0] enq_data;
  logic          iwb_v, iwb_yumi, fwb_v, fwb_yumi;
  logic [AW-1:0] iwb_rd_addr, fwb_rd_addr, probe_rd_addr;
  logic [DW-1:0] iwb_data, fwb_data;
  logic          probe_float, probe_hit;
  logic [2:0]    count;
  bit            check_en = 1'b0;
  int            total = 0;
  int            bad = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;
  ent_t int_q[$];
  ent_t fp_q[$];

  always #5 clk = ~clk;

  bp_be_late_wb_queue #(.els_p(Els), .data_width_p(DW), .reg_addr_width_p(AW)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .enq_v_i(enq_v), .enq_ready_o(enq_ready), .enq_float_i(enq_float),
    .enq_rd_addr_i(enq_rd_addr), .enq_data_i(enq_data),
    .iwb_v_o(iwb_v), .iwb_rd_addr_o(iwb_rd_addr), .iwb_data_o(iwb_data), .iwb_yumi_i(iwb_yumi),
    .fwb_v_o(fwb_v), .fwb_rd_addr_o(fwb_rd_addr), .fwb_data_o(fwb_data), .fwb_yumi_i(fwb_yumi),
    .probe_rd_addr_i(probe_rd_addr), .probe_float_i(probe_float), .probe_hit_o(probe_hit),
    .count_o(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: one FIFO per class, a shared capacity of Els.
  function automatic bit m_ready();
    return (int_q.size() + fp_q.size()) < Els;
  endfunction

  function automatic bit m_byp_int();
`ifdef BP_BE_LATE_WB_BYPASS_EN
    return enq_v && m_ready() && !enq_float && (enq_rd_addr != 0) && (int_q.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_byp_fp();
`ifdef BP_BE_LATE_WB_BYPASS_EN
    return enq_v && m_ready() && enq_float && (fp_q.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_iwb_v();
    return (int_q.size() != 0) || m_byp_int();
  endfunction

  function automatic bit m_fwb_v();
    return (fp_q.size() != 0) || m_byp_fp();
  endfunction

  function automatic bit m_probe();
    if (!probe_float && probe_rd_addr == 0) return 1'b0;
    if (probe_float) begin
      foreach (fp_q[i]) if (fp_q[i].addr == probe_rd_addr) return 1'b1;
    end else begin
      foreach (int_q[i]) if (int_q[i].addr == probe_rd_addr) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic compare_outputs();
    chk("enq_ready", enq_ready, m_ready());
    chk("count", count, int_q.size() + fp_q.size());
    chk("iwb_v", iwb_v, m_iwb_v());
    if (m_iwb_v()) begin
      chk("iwb_addr", iwb_rd_addr, (int_q.size() != 0) ? int_q[0].addr : enq_rd_addr);
      chk("iwb_data", iwb_data, (int_q.size() != 0) ? int_q[0].data : enq_data);
    end
    chk("fwb_v", fwb_v, m_fwb_v());
    if (m_fwb_v()) begin
      chk("fwb_addr", fwb_rd_addr, (fp_q.size() != 0) ? fp_q[0].addr : enq_rd_addr);
      chk("fwb_data", fwb_data, (fp_q.size() != 0) ? fp_q[0].data : enq_data);
    end
    chk("probe_hit", probe_hit, m_probe());
  endtask

  task automatic model_step();
    bit   acc, bi, bf;
    ent_t e;
    acc = enq_v && m_ready();
    bi  = m_byp_int();
    bf  = m_byp_fp();
    if (iwb_yumi && int_q.size() != 0) void'(int_q.pop_front());
    if (fwb_yumi && fp_q.size() != 0) void'(fp_q.pop_front());
    if (acc && !(!enq_float && enq_rd_addr == 0) && !(bi && iwb_yumi) && !(bf && fwb_yumi)) begin
      e.addr = enq_rd_addr;
      e.data = enq_data;
      if (enq_float) fp_q.push_back(e);
      else int_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (reset_n && check_en) compare_outputs();
  end

  always @(posedge clk) begin
    if (reset_n) model_step();
  end

  task automatic drive(input bit v, input bit f, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit iy, input bit fy, input bit pf, input logic [AW-1:0] pa);
    @(negedge clk);
    enq_v = v; enq_float = f; enq_rd_addr = a; enq_data = d;
    iwb_yumi = iy; fwb_yumi = fy; probe_float = pf; probe_rd_addr = pa;
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    enq_v = 0; enq_float = 0; enq_rd_addr = '0; enq_data = '0;
    iwb_yumi = 0; fwb_yumi = 0; probe_float = 0; probe_rd_addr = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready", enq_ready, 1);
    chk("rst_iwb_v", iwb_v, 0);
    chk("rst_fwb_v", fwb_v, 0);
    chk("rst_probe", probe_hit, 0);
    #10 reset_n = 1'b1;
    check_en = 1'b1;

    // Same-register ordering and probe.
    drive(1, 0, 5, 64'hA, 0, 0, 0, 5);
    drive(1, 0, 5, 64'hB, 0, 0, 0, 5);
    drive(0, 0, 0, 0, 1, 0, 0, 5);
    chk("s1_first", iwb_data, 64'hA);
    chk("s1_probe_a", probe_hit, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 5);
    chk("s1_second", iwb_data, 64'hB);
    chk("s1_probe_b", probe_hit, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 5);
    chk("s1_empty_v", iwb_v, 0);
    chk("s1_probe_c", probe_hit, 0);

    // Independent class dequeues.
    drive(1, 0, 3, 64'h3, 0, 0, 0, 0);
    drive(1, 1, 3, 64'h33, 0, 0, 0, 0);
    drive(1, 0, 4, 64'h4, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    chk("s2_count3", count, 3);
    chk("s2_iwb_addr", iwb_rd_addr, 3);
    chk("s2_fwb_addr", fwb_rd_addr, 3);
    chk("s2_fwb_data", fwb_data, 64'h33);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("s2_count1", count, 1);
    chk("s2_iwb_addr4", iwb_rd_addr, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s2_count0", count, 0);

    // Full queue behaviour.
    for (int i = 1; i <= 4; i++) drive(1, 0, AW'(i), DW'(16 + i), 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_full_ready", enq_ready, 0);
    chk("s3_full_count", count, 4);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_ready_after", enq_ready, 1);
    chk("s3_count3", count, 3);
    drive(1, 0, 9, 64'h99, 0, 0, 0, 0);
    drive(1, 0, 10, 64'hAA, 1, 0, 0, 10);
    chk("s3_ready_full", enq_ready, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 10);
    chk("s3_rejected_count", count, 3);
    chk("s3_rejected_probe", probe_hit, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_drained", count, 0);

    // x0 discard.
    drive(1, 0, 0, 64'hFF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s4_count", count, 0);
    chk("s4_iwb_v", iwb_v, 0);
    chk("s4_probe", probe_hit, 0);

    // Asynchronous reset mid-operation.
    drive(1, 0, 1, 64'h1, 0, 0, 0, 0);
    drive(1, 1, 2, 64'h2, 0, 0, 0, 0);
    drive(1, 0, 6, 64'h6, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    chk("s5_count", count, 0);
    chk("s5_iwb_v", iwb_v, 0);
    chk("s5_fwb_v", fwb_v, 0);
    chk("s5_probe", probe_hit, 0);
    int_q.delete();
    fp_q.delete();
    #1 reset_n = 1'b1;
    #1;
    chk("s5_ready", enq_ready, 1);

`ifdef BP_BE_LATE_WB_BYPASS_EN
    drive(1, 1, 7, 64'h1234, 0, 1, 0, 0);
    chk("s6_fwb_v", fwb_v, 1);
    chk("s6_fwb_data", fwb_data, 64'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s6_count", count, 0);
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      enq_v         = ($urandom_range(0, 3) != 0);
      enq_float     = $urandom_range(0, 1);
      enq_rd_addr   = AW'($urandom_range(0, 7));
      enq_data      = {$urandom, $urandom};
      probe_float   = $urandom_range(0, 1);
      probe_rd_addr = AW'($urandom_range(0, 7));
      iwb_yumi      = m_iwb_v() && ($urandom_range(0, 2) == 0);
      fwb_yumi      = m_fwb_v() && ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    enq_v = 0; iwb_yumi = 0; fwb_yumi = 0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
